// File: rtl/data_sync_gen.sv
// data_sync_gen: carries a data bus and its level enable from a foreign
// clock domain into CLK. The enable is resynchronised through a flop chain,
// edge-detected into a single-cycle pulse, and that pulse captures the bus,
// starts a stretched strobe and flags transfers that arrive too early.
module data_sync_gen #(
   parameter int BUS_WIDTH  = 8,
   parameter int NUM_STAGES = 2,
   parameter int EDGE_MODE  = 0,
   parameter int PULSE_LEN  = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 bus_enable,
   input  logic [BUS_WIDTH-1:0] unsync_bus,
   input  logic                 clr_err,
   output logic                 pulse,
   output logic                 enable_pulse,
   output logic [BUS_WIDTH-1:0] sync_bus,
   output logic                 overrun
);

   localparam int CW = $clog2(PULSE_LEN + 1);

   logic [NUM_STAGES-1:0] r_sync;
   logic                  r_prev;
   logic [CW-1:0]         r_cnt;
   logic                  r_en;
   logic [BUS_WIDTH-1:0]  r_bus;
   logic                  r_ovr;

   logic                  w_sync_en;
   logic                  w_pulse;
   logic [CW-1:0]         w_cnt_next;
   logic                  w_retrig_early;

   assign w_sync_en = r_sync[NUM_STAGES-1];

   // Selected edge of the synchronised enable; unknown modes fall back to rising.
   generate
      if (EDGE_MODE == 1) begin : g_fall
         assign w_pulse = ~w_sync_en & r_prev;
      end else if (EDGE_MODE == 2) begin : g_both
         assign w_pulse = w_sync_en ^ r_prev;
      end else begin : g_rise
         assign w_pulse = w_sync_en & ~r_prev;
      end
   endgenerate

   // A pulse reloads the stretch counter; otherwise it runs down to zero.
   always_comb begin
      w_cnt_next = r_cnt;
      if (w_pulse) begin
         w_cnt_next = CW'(PULSE_LEN);
      end else if (r_cnt != '0) begin
         w_cnt_next = r_cnt - CW'(1);
      end
   end

   // Retrigger is only an error while more than the final strobe cycle remains.
   assign w_retrig_early = w_pulse && (r_cnt > CW'(1));

   // Synchroniser chain plus one cycle of edge history.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[NUM_STAGES-2:0], bus_enable};
         r_prev <= w_sync_en;
      end
   end

   // Stretch counter and the registered strobe derived from its next value.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cnt <= '0;
         r_en  <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         r_en  <= (w_cnt_next != '0);
      end
   end

   // Capture the foreign bus on each detected edge, hold otherwise.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_bus <= '0;
      end else if (w_pulse) begin
         r_bus <= unsync_bus;
      end
   end

   // Sticky overrun; a set in the same cycle as a clear takes priority.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_ovr <= 1'b0;
      end else if (w_retrig_early) begin
         r_ovr <= 1'b1;
      end else if (clr_err) begin
         r_ovr <= 1'b0;
      end
   end

   assign pulse        = w_pulse;
   assign enable_pulse = r_en;
   assign sync_bus     = r_bus;
   assign overrun      = r_ovr;

endmodule
